// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 33-cycle latency, start/busy/done handshake
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t r_state;
  logic [4:0] r_cnt;
  logic [2:0] r_op;
  logic r_neg, r_sa;
  logic [XLEN-1:0] r_m, r_hi, r_lo;
  logic w_sa, w_sb;
  logic [XLEN-1:0] w_ma, w_mb, w_quo, w_rem, w_res;
  logic [XLEN:0] w_sum, w_sh, w_dif;
  logic [2*XLEN-1:0] w_prod;
  assign w_sa = ((op == 3'b001) || (op == 3'b010) || (op[2] && !op[0])) && a[XLEN-1];
  assign w_sb = ((op == 3'b001) || (op[2] && !op[0])) && b[XLEN-1];
  assign w_ma = w_sa ? -a : a;
  assign w_mb = w_sb ? -b : b;
  // r_hi:r_lo is the product accumulator for multiplies, remainder:quotient for divides
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_sh = {r_hi, r_lo[XLEN-1]};
  assign w_dif = w_sh - {1'b0, r_m};
  assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo = r_neg ? -r_lo : r_lo;
  assign w_rem = r_sa ? -r_hi : r_hi;
  assign w_res = r_op[2] ? (r_op[1] ? w_rem : w_quo)
               : (r_op[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_op <= '0;
      r_neg <= 1'b0;
      r_sa <= 1'b0;
      r_m <= '0;
      r_hi <= '0;
      r_lo <= '0;
      result <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_op <= op;
          r_sa <= w_sa;
          // divide by zero keeps the all-ones quotient unnegated; remainder falls out as a
          r_neg <= (w_sa ^ w_sb) & ~(op[2] & (b == '0));
          r_m <= op[2] ? w_mb : w_ma;
          r_lo <= op[2] ? w_ma : w_mb;
          r_hi <= '0;
          r_cnt <= '0;
          busy <= 1'b1;
          r_state <= CALC;
        end
        CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_op[2]) begin
            r_hi <= w_dif[XLEN] ? w_sh[XLEN-1:0] : w_dif[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], ~w_dif[XLEN]};
          end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
          if (r_cnt == 5'd31) r_state <= FINISH;
        end
        FINISH: begin
          result <= w_res;
          done <= 1'b1;
          busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit with an expected-result queue
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b1;
  logic [2:0] op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t1, t2;
  logic [31:0] sq[$];
  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // called at a negedge; returns at the negedge of the done cycle
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input bit poke, output int t);
    int n;
    bit bad;
    logic [31:0] want;
    op = o; a = x; b = y; start = 1'b1;
    sq.push_back(e);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    n = 0; bad = 0;
    while (!done && n < 40) begin
      if (poke && n == 10) begin start = 1'b1; op = 3'b100; end else start = 1'b0;
      @(negedge clk);
      n++;
      if (busy && done) bad = 1;
      if (!busy && !done) bad = 1;
    end
    start = 1'b0;
    chk({tag, ".lat"}, 32'(n), 32'd33);
    chk({tag, ".overlap"}, 32'(bad), 32'd0);
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    want = sq.size() > 0 ? sq[0] : 32'hDEAD_BEEF;
    if (sq.size() > 0) void'(sq.pop_front());
    chk({tag, ".res"}, result, want);
    t = cyc;
  endtask
  initial begin
    int n;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst.result", result, 32'h0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst.start_ignored", 32'(busy), 32'd0);
    do_op("mul", 3'b000, 32'd10, 32'd5, 32'h0000_0032, 0, t1);
    @(negedge clk);
    chk("mul.done_pulse", 32'(done), 32'd0);
    repeat (9) @(negedge clk);
    chk("mul.hold", result, 32'h0000_0032);
    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, t1);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, t1);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, t1);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, t1);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, t1);
    do_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 0, t1);
    do_op("remu", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 0, t1);
    do_op("div0", 3'b100, 32'd20, 32'd0, 32'hFFFF_FFFF, 0, t1);
    do_op("remu0", 3'b111, 32'd20, 32'd0, 32'h0000_0014, 0, t1);
    do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, t1);
    do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, t1);
    do_op("mulneg", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 0, t1);
    do_op("poke", 3'b000, 32'd7, 32'd6, 32'd42, 1, t1);
    do_op("chain1", 3'b000, 32'd100, 32'd3, 32'd300, 0, t1);
    do_op("chain2", 3'b111, 32'd100, 32'd7, 32'd2, 0, t2);
    chk("chain.gap", 32'(t2 - t1), 32'd34);
    op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("abort.no_done", 32'(seen), 32'd0);
    do_op("after_abort", 3'b000, 32'd3, 32'd4, 32'h0000_000C, 0, t1);
    chk("sb.empty", 32'(sq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
